fifo_rd_ctrl: RTL and testbench
===============================

# fifo_rd_ctrl

Read-side controller of the asynchronous FIFO, sitting directly downstream of the two-port RAM in the read clock domain. It owns the read pointer, derives empty from the synchronized write pointer, and issues RAM reads with `en_rd` held high so the RAM output pipeline advances every cycle. Read data is captured into a small skid buffer and presented as a first-word-fall-through valid/ready stream at full throughput, independent of the RAM's read latency.

## Interface
- `DATA_WIDTH`, 32, word width; must match the RAM.
- `ADDR_WIDTH`, 4, RAM address width. FIFO depth is 2**ADDR_WIDTH.
- `RD_LATENCY`, 1, RAM output register stages (the RAM's `OUTPUT_REG`); must be ≥1, elaboration error otherwise.
- `clk_rd` in 1: read-domain clock. The block has one clock.
- `rst` in 1: asynchronous, active-high reset.
- `wr_ptr_gray_sync` in ADDR_WIDTH+1: write pointer, Gray-coded, already synchronized into `clk_rd`.
- `rd_ptr_gray` out ADDR_WIDTH+1: registered Gray read pointer, exported to the write-domain synchronizer.
- `ram_en_rd` out 1: RAM read enable.
- `ram_addr_rd` out ADDR_WIDTH: RAM read address.
- `ram_data_rd` in DATA_WIDTH: RAM read data.
- `m_valid` out 1: output word available.
- `m_ready` in 1: consumer accepts the word.
- `m_data` out DATA_WIDTH: output word.

## Operation
- `rd_ptr_bin` is ADDR_WIDTH+1 bits and wraps naturally. `rd_ptr_gray` is registered from `next_bin ^ (next_bin >> 1)`, so it changes at most one bit per cycle.
- `empty` = (`rd_ptr_gray` == `wr_ptr_gray_sync`).
- `ram_addr_rd` = `rd_ptr_bin[ADDR_WIDTH-1:0]`.
- `ram_en_rd` is a register: 0 in reset, constant 1 thereafter.
- Credit rule: `pop` = `m_valid & m_ready`. `issue` = `!empty & (inflight + buf_cnt - pop < RD_LATENCY+1)`.
- On `issue`, `rd_ptr_bin` increments.
- `vpipe[RD_LATENCY-1:0]` tags in-flight reads:
  - `vpipe[0] <= issue`.
  - `vpipe[k] <= vpipe[k-1]`.
  - When `vpipe[RD_LATENCY-1]` is 1, `ram_data_rd` is written into the skid buffer.
- `inflight` = popcount of `vpipe`, kept as a counter incremented on `issue` and decremented on capture.
- Skid buffer:
  - Depth RD_LATENCY+1, FIFO order.
  - `m_valid` = (`buf_cnt` != 0); `m_data` = buffer head.
  - No combinational bypass from RAM to output.
- Capture and pop in the same cycle are legal. The credit rule guarantees the buffer never overflows, with no further check required.

## Timing
- Reset values:
  - `rd_ptr_bin`, `rd_ptr_gray`: 0.
  - `ram_en_rd`: 0.
  - `vpipe`, `inflight`, `buf_cnt`: 0.
  - `m_valid`: 0; `m_data`: 0.
- Reset asserted mid-operation discards all in-flight reads and buffered words immediately (asynchronous clear). The write domain must be reset together with it.
- Latency: for an issue at edge E, the word is captured at edge E+RD_LATENCY, and `m_valid` is high after that edge.
- From `wr_ptr_gray_sync` changing (FIFO previously empty) to `m_valid`: RD_LATENCY+1 edges.
- Throughput: one word per cycle sustained while not empty and `m_ready` is held high.
- `m_valid`/`m_data` are stable while `m_ready` is low. `m_valid` never drops without a pop.
- Wrap-around: pointer rollover from 2**(ADDR_WIDTH+1)-1 to 0 is seamless. Empty detection is unaffected because it uses full-width Gray equality.

## Structure
- Shared package `afifo_pkg`:
  - `bin2gray` function.
  - Pointer-width localparam derivation (ADDR_WIDTH+1).
  - Parameter checks shared with the write-side controller.
- Sub-module `rd_skid_fifo`: parameterized DATA_WIDTH × (RD_LATENCY+1) register FIFO with push/pop/count, asynchronous active-high reset.
- Pointer, credit and `vpipe` logic stay in `fifo_rd_ctrl`.

## Test plan
- Reset, then write domain idle (`wr_ptr_gray_sync`=0) → `m_valid`=0, `rd_ptr_gray`=0, no pointer movement for 20 cycles.
- RD_LATENCY=1 (the RAM's `OUTPUT_REG`), 4 words 0xA0..0xA3 present (`wr_ptr_gray_sync`=gray(4)), `m_ready`=1 → `m_valid` rises 2 edges after the pointer update; words appear on consecutive cycles in order; `rd_ptr_gray` ends at gray(4)=0x6.
- RD_LATENCY=3, FIFO full (16 words), `m_ready` low for 10 cycles then high → exactly 4 words issued while stalled (`buf_cnt`+`inflight`=4); then 16 words delivered in order back-to-back with no gaps.
- Random `m_ready` (50%), 1000 words, pointer wrapping ≥3 times → scoreboard matches order exactly; `rd_ptr_gray` changes ≤1 bit per cycle; no buffer overflow.
- `rst` asserted mid-burst with 2 words in flight → all outputs return to reset values asynchronously before the next edge; after release, the bench re-presents `wr_ptr_gray_sync` from 0 and reads resume correctly.

Source files
------------

// File: rtl/afifo_pkg.sv
// afifo_pkg: pointer-width, Gray-code and parameter-check helpers shared by both async FIFO controllers
package afifo_pkg;
    localparam int GRAY_CALC_W = 32;

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic logic [GRAY_CALC_W-1:0] bin2gray(input logic [GRAY_CALC_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic bit params_ok(input int addr_width, input int rd_latency);
        return addr_width >= 1 && addr_width < GRAY_CALC_W && rd_latency >= 1;
    endfunction
endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if: first-word-fall-through valid/ready output stream of the FIFO read side
interface fifo_rd_ctrl_if #(parameter int DATA_WIDTH = 32);
    logic valid;
    logic ready;
    logic [DATA_WIDTH-1:0] data;
    modport master(output valid, data, input ready);
    modport slave(input valid, data, output ready);
endinterface

// File: rtl/rd_skid_fifo.sv
// rd_skid_fifo: small register FIFO absorbing the RAM read latency in front of the output stream
module rd_skid_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int IW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [DATA_WIDTH-1:0] head,
    output logic [CW-1:0] count
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [IW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [CW-1:0] count_q, count_d;

    // DEPTH need not be a power of two, so indices wrap explicitly
    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
        return i == IW'(DEPTH - 1) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_idx_q] = push_data;
        wr_idx_d = push ? nxt(wr_idx_q) : wr_idx_q;
        rd_idx_d = pop ? nxt(rd_idx_q) : rd_idx_q;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            mem_q <= '{default: '0};
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            count_q <= count_d;
        end

    assign head = mem_q[rd_idx_q];
    assign count = count_q;
endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: async FIFO read side - pointer, empty, credit-limited RAM reads and FWFT skid output
module fifo_rd_ctrl import afifo_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic clk_rd,
    input  logic rst,
    input  logic [ADDR_WIDTH:0] wr_ptr_gray_sync,
    output logic [ADDR_WIDTH:0] rd_ptr_gray,
    output logic ram_en_rd,
    output logic [ADDR_WIDTH-1:0] ram_addr_rd,
    input  logic [DATA_WIDTH-1:0] ram_data_rd,
    fifo_rd_ctrl_if.master m
);
    localparam int PW = ptr_width(ADDR_WIDTH);
    localparam int BD = RD_LATENCY + 1;
    localparam int CW = $clog2(BD + 1);

    if (!params_ok(ADDR_WIDTH, RD_LATENCY)) begin : g_param_err
        $error("fifo_rd_ctrl: RD_LATENCY must be >= 1 and ADDR_WIDTH in range");
    end

    logic [PW-1:0] rd_ptr_bin_q, rd_ptr_bin_d, rd_ptr_gray_q, rd_ptr_gray_d;
    logic [RD_LATENCY-1:0] vpipe_q, vpipe_d;
    logic [CW-1:0] inflight_q, inflight_d, buf_cnt;
    logic [DATA_WIDTH-1:0] head;
    logic ram_en_rd_q, empty, pop, issue, capture;

    // Reads in flight plus buffered words never exceed the skid depth, so captures always fit
    always_comb begin
        empty = rd_ptr_gray_q == wr_ptr_gray_sync;
        pop = m.valid & m.ready;
        capture = vpipe_q[RD_LATENCY-1];
        issue = !empty && (32'(inflight_q) + 32'(buf_cnt) - 32'(pop) < 32'(BD));
        rd_ptr_bin_d = rd_ptr_bin_q + PW'(issue);
        rd_ptr_gray_d = PW'(bin2gray(GRAY_CALC_W'(rd_ptr_bin_d)));
        vpipe_d = RD_LATENCY'({vpipe_q, issue});
        inflight_d = inflight_q + CW'(issue) - CW'(capture);
    end

    always_ff @(posedge clk_rd or posedge rst)
        if (rst) begin
            rd_ptr_bin_q <= '0;
            rd_ptr_gray_q <= '0;
            vpipe_q <= '0;
            inflight_q <= '0;
            ram_en_rd_q <= 1'b0;
        end else begin
            rd_ptr_bin_q <= rd_ptr_bin_d;
            rd_ptr_gray_q <= rd_ptr_gray_d;
            vpipe_q <= vpipe_d;
            inflight_q <= inflight_d;
            ram_en_rd_q <= 1'b1;
        end

    rd_skid_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(BD)) u_skid (
        .clk(clk_rd),
        .rst(rst),
        .push(capture),
        .pop(pop),
        .push_data(ram_data_rd),
        .head(head),
        .count(buf_cnt)
    );

    assign rd_ptr_gray = rd_ptr_gray_q;
    assign ram_en_rd = ram_en_rd_q;
    assign ram_addr_rd = rd_ptr_bin_q[ADDR_WIDTH-1:0];
    assign m.valid = buf_cnt != '0;
    assign m.data = head;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: scoreboard bench driving RD_LATENCY=1 and RD_LATENCY=3 read controllers in lockstep
module tb_fifo_rd_ctrl;
    localparam int DW = 32, AW = 4, DEPTH = 16;

    logic clk = 1'b0, rst = 1'b1, ready = 1'b0;
    logic [AW:0] wr_ptr_gray_sync = '0;
    logic [AW:0] g1, g3;
    logic en1, en3;
    logic [AW-1:0] a1, a3;
    logic [DW-1:0] d1, d3;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] p1 [1];
    logic [DW-1:0] p3 [3];
    logic [DW-1:0] q1 [$];
    logic [DW-1:0] q3 [$];
    int checks = 0, failures = 0, wr_bin = 0;

    fifo_rd_ctrl_if #(.DATA_WIDTH(DW)) s1 ();
    fifo_rd_ctrl_if #(.DATA_WIDTH(DW)) s3 ();
    assign s1.ready = ready;
    assign s3.ready = ready;

    fifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1)) u_l1 (
        .clk_rd(clk), .rst(rst), .wr_ptr_gray_sync(wr_ptr_gray_sync), .rd_ptr_gray(g1),
        .ram_en_rd(en1), .ram_addr_rd(a1), .ram_data_rd(d1), .m(s1));
    fifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(3)) u_l3 (
        .clk_rd(clk), .rst(rst), .wr_ptr_gray_sync(wr_ptr_gray_sync), .rd_ptr_gray(g3),
        .ram_en_rd(en3), .ram_addr_rd(a3), .ram_data_rd(d3), .m(s3));

    always #5 clk = ~clk;

    // RAM read ports: one and three output register stages
    always @(posedge clk) if (en1) p1[0] <= mem[a1];
    always @(posedge clk) if (en3) begin
        p3[0] <= mem[a3];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign d1 = p1[0];
    assign d3 = p3[2];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [AW:0] gray(input int b);
        logic [AW:0] x;
        x = (AW + 1)'(b);
        return x ^ (x >> 1);
    endfunction

    function automatic int g2b(input logic [AW:0] g);
        logic [AW:0] r;
        r[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) r[i] = r[i + 1] ^ g[i];
        return int'(r);
    endfunction

    function automatic int occ(input logic [AW:0] g);
        return (wr_bin - g2b(g)) & 31;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input logic [DW-1:0] base, input bit rnd);
        for (int i = 0; i < n; i++) begin
            logic [DW-1:0] w;
            w = rnd ? DW'($urandom) : base + DW'(i);
            mem[wr_bin % DEPTH] = w;
            q1.push_back(w);
            q3.push_back(w);
            wr_bin++;
        end
        wr_ptr_gray_sync = gray(wr_bin);
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && (q1.size() != 0 || q3.size() != 0); k++) tick(1);
        check("drain_q1_empty", q1.size(), 0);
        check("drain_q3_empty", q3.size(), 0);
    endtask

    logic [AW:0] pg1, pg3;
    logic hold1, hold3;
    logic [DW-1:0] hd1, hd3;

    always @(negedge clk) begin
        if (rst) begin
            pg1 <= '0;
            hold1 <= 1'b0;
        end else begin
            check("l1_gray_step", $countones(g1 ^ pg1) <= 1, 1);
            if (hold1) begin
                check("l1_stall_valid", s1.valid, 1);
                check("l1_stall_data", s1.data, hd1);
            end
            if (s1.valid && s1.ready) begin
                check("l1_q_nonempty", q1.size() != 0, 1);
                if (q1.size() != 0) check("l1_data", s1.data, q1.pop_front());
            end
            pg1 <= g1;
            hold1 <= s1.valid && !s1.ready;
            hd1 <= s1.data;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            pg3 <= '0;
            hold3 <= 1'b0;
        end else begin
            check("l3_gray_step", $countones(g3 ^ pg3) <= 1, 1);
            if (hold3) begin
                check("l3_stall_valid", s3.valid, 1);
                check("l3_stall_data", s3.data, hd3);
            end
            if (s3.valid && s3.ready) begin
                check("l3_q_nonempty", q3.size() != 0, 1);
                if (q3.size() != 0) check("l3_data", s3.data, q3.pop_front());
            end
            pg3 <= g3;
            hold3 <= s3.valid && !s3.ready;
            hd3 <= s3.data;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e1, e3, v1, v3, l1, l3, n, guard, base;
        tick(2);
        check("rst_valid1", s1.valid, 0);
        check("rst_valid3", s3.valid, 0);
        check("rst_data1", s1.data, 0);
        check("rst_data3", s3.data, 0);
        check("rst_en1", en1, 0);
        check("rst_en3", en3, 0);
        check("rst_gray3", g3, 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("idle_valid1", s1.valid, 0);
            check("idle_valid3", s3.valid, 0);
            check("idle_gray1", g1, 0);
            check("idle_gray3", g3, 0);
        end
        check("run_en1", en1, 1);

        ready = 1'b1;
        e1 = 0; e3 = 0; v1 = 0; v3 = 0; l1 = 0; l3 = 0;
        load(4, 32'hA0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (s1.valid) begin v1++; l1 = k; if (e1 == 0) e1 = k; end
            if (s3.valid) begin v3++; l3 = k; if (e3 == 0) e3 = k; end
        end
        check("lat1_edges", e1, 2);
        check("lat3_edges", e3, 4);
        check("burst1_span", l1 - e1 + 1, 4);
        check("burst3_span", l3 - e3 + 1, 4);
        check("burst1_len", v1, 4);
        check("burst3_len", v3, 4);
        check("gray4_l1", g1, 6);
        check("gray4_l3", g3, 6);
        check("q1_after_burst", q1.size(), 0);

        ready = 1'b0;
        load(16, 32'h100, 1'b0);
        tick(10);
        check("stall_issued1", (g2b(g1) - 4) & 31, 2);
        check("stall_issued3", (g2b(g3) - 4) & 31, 4);
        ready = 1'b1;
        v1 = 0; v3 = 0;
        for (int k = 0; k < 16; k++) begin
            v1 += int'(s1.valid);
            v3 += int'(s3.valid);
            tick(1);
        end
        check("b2b_len1", v1, 16);
        check("b2b_len3", v3, 16);
        check("b2b_end_valid1", s1.valid, 0);
        check("b2b_end_valid3", s3.valid, 0);
        check("full_gray1", g1, gray(20));

        n = 0; guard = 0;
        while (n < 1000 && guard < 20000) begin
            ready = 1'($urandom_range(0, 1));
            if (DEPTH - (occ(g1) > occ(g3) ? occ(g1) : occ(g3)) > 0 && $urandom_range(0, 3) != 0) begin
                load(1, '0, 1'b1);
                n++;
            end
            tick(1);
            guard++;
        end
        check("rand_words_written", n, 1000);
        ready = 1'b1;
        drain();
        check("rand_gray1", g1, gray(wr_bin));
        check("rand_gray3", g3, gray(wr_bin));

        ready = 1'b0;
        base = wr_bin;
        load(8, 32'hC0, 1'b0);
        tick(2);
        check("pre_rst_valid1", s1.valid, 1);
        check("pre_rst_issued3", (g2b(g3) - base) & 31, 2);
        #2;
        rst = 1'b1;
        #1;
        check("async_valid1", s1.valid, 0);
        check("async_valid3", s3.valid, 0);
        check("async_data1", s1.data, 0);
        check("async_gray1", g1, 0);
        check("async_gray3", g3, 0);
        check("async_en3", en3, 0);
        check("async_addr3", a3, 0);
        q1.delete();
        q3.delete();
        wr_bin = 0;
        wr_ptr_gray_sync = '0;
        tick(2);
        rst = 1'b0;
        tick(3);
        ready = 1'b1;
        load(5, '0, 1'b1);
        tick(1);
        drain();
        check("post_rst_gray1", g1, gray(5));
        check("post_rst_gray3", g3, gray(5));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
